axi_rd_arbiter: RTL and testbench

- Shares one AXI read channel (AR/R) between N cache-side read ports, e.g. icache port 0 and dcache port 1.
- Each port uses the cache miss protocol: rd_req/rd_type/rd_addr/rd_rdy request, ret_valid/ret_last/ret_data refill.
- Round-robin arbitration, one outstanding transaction per port, R beats routed back by rid.
- Blocks a read that hits a line still pending in the write buffer, avoiding read-after-write staleness.

---
 rtl/axi_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI AR/R channel among N_REQ
// cache read ports, one outstanding burst per port, R beats routed by rid.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   rd_req/type/addr     per-port requests (held until rd_rdy)
//   rd_rdy               one-hot grant pulse
//   ret_valid/last/data  per-port refill beats (data broadcast)
//   wb_busy/wb_addr      pending write-buffer line (blocks same-line reads)
//   ar*/r*               AXI read address / read data channels
module axi_rd_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [N_REQ-1:0]      rd_req,
   input  logic [3*N_REQ-1:0]    rd_type,
   input  logic [32*N_REQ-1:0]   rd_addr,
   output logic [N_REQ-1:0]      rd_rdy,
   output logic [N_REQ-1:0]      ret_valid,
   output logic [N_REQ-1:0]      ret_last,
   output logic [31:0]           ret_data,
   input  logic                  wb_busy,
   input  logic [31:0]           wb_addr,
   output logic [ID_W-1:0]       arid,
   output logic [31:0]           araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [ID_W-1:0]       rid,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready
);

   logic [N_REQ-1:0] out_q, out_d;
   logic [N_REQ-1:0] elig, gnt;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic [ID_W-1:0]  arid_q, arid_d, g_idx;
   logic [31:0]      araddr_q, araddr_d;
   logic [7:0]       arlen_q, arlen_d, len_n;
   logic [2:0]       arsize_q, arsize_d, size_n, ty;
   logic             arvalid_q, arvalid_d;
   logic             slot_free, any_gnt;
   logic             unused_ok;

   assign unused_ok = ^{rresp, wb_addr[3:0]};
   assign slot_free = !arvalid_q || arready;

   // A read to the line still sitting in the write buffer would
   // fetch stale memory, so it waits until the write is acknowledged.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = rd_req[i] && !out_q[i] &&
                   !(wb_busy && rd_addr[32*i+4 +: 28] == wb_addr[31:4]);
      end
   end

   // Scan from rr+1 so the last winner has lowest priority.
   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      g_idx   = '0;
      any_gnt = 1'b0;
      if (slot_free && resetn) begin
         for (int k = 1; k <= N_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any_gnt && elig[j]) begin
               any_gnt  = 1'b1;
               g_idx    = ID_W'(j);
               gnt[j]   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ty     = rd_type[3*int'(g_idx) +: 3];
      len_n  = 8'd0;
      size_n = 3'd2;
      case (ty)
         3'b100:  len_n  = 8'd3;
         3'b001:  size_n = 3'd1;
         3'b000:  size_n = 3'd0;
         default: size_n = 3'd2;
      endcase
   end

   always_comb begin
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      if (any_gnt) begin
         arvalid_d = 1'b1;
         arid_d    = g_idx;
         araddr_d  = rd_addr[32*int'(g_idx) +: 32];
         arlen_d   = len_n;
         arsize_d  = size_n;
      end else if (arready) begin
         arvalid_d = 1'b0;
      end
      out_d = (out_q & ~ret_last) | gnt;
      rr_d  = any_gnt ? g_idx : rr_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         out_q     <= '0;
         rr_q      <= ID_W'(N_REQ - 1);
      end else begin
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         out_q     <= out_d;
         rr_q      <= rr_d;
      end
   end

   // Beats for unknown ids or idle ports are accepted and dropped.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         ret_valid[i] = resetn && rvalid && rid == ID_W'(i) && out_q[i];
         ret_last[i]  = ret_valid[i] && rlast;
      end
   end

   assign ret_data = rdata;
   assign rd_rdy   = gnt;
   assign arvalid  = arvalid_q;
   assign arid     = arid_q;
   assign araddr   = araddr_q;
   assign arlen    = arlen_q;
   assign arsize   = arsize_q;
   assign arburst  = 2'b01;
   assign rready   = 1'b1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: random requesters, write-buffer hazards and an
// interleaving AXI slave, checked against a queue-based reference model.
module tb_axi_rd_arbiter;
   localparam int N  = 2;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    rd_req, rd_rdy, ret_valid, ret_last;
   logic [3*N-1:0]  rd_type;
   logic [32*N-1:0] rd_addr;
   logic [31:0]     ret_data, wb_addr, araddr, rdata;
   logic            wb_busy, arvalid, arready, rlast, rvalid, rready;
   logic [IW-1:0]   arid, rid;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst, rresp;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .resetn(resetn),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
      .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
      .ret_data(ret_data), .wb_busy(wb_busy), .wb_addr(wb_addr),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      logic [IW-1:0] id;
      logic [31:0]   addr;
      logic [7:0]    len;
      logic [2:0]    size;
   } ar_t;
   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic [31:0]  d;
   } ret_t;
   typedef struct {
      int id;
      int left;
   } burst_t;

   ar_t    ar_q[$];
   ret_t   ret_q[$];
   burst_t bq[$];

   int       n_chk = 0;
   int       n_fail = 0;
   bit [N-1:0] outst_m = '0;
   bit [N-1:0] gnt_m = '0;
   int       rr_m = N - 1;
   bit       beat_hit = 0;
   bit       beat_last = 0;
   int       beat_id = 0;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   function automatic bit elig(input int j);
      return rd_req[j] && !outst_m[j] &&
             !(wb_busy && rd_addr[32*j+4 +: 28] == wb_addr[31:4]);
   endfunction

   // Monitor: compares DUT outputs with queued expectations.
   always @(negedge clk) begin
      ar_t  e;
      ret_t r;
      chk("rready", {63'd0, rready}, 64'd1);
      if (ar_q.size() > 0) begin
         e = ar_q[0];
         chk("arvalid", {63'd0, arvalid}, 64'd1);
         chk("arid", {60'd0, arid}, {60'd0, e.id});
         chk("araddr", {32'd0, araddr}, {32'd0, e.addr});
         chk("arlen", {56'd0, arlen}, {56'd0, e.len});
         chk("arsize", {61'd0, arsize}, {61'd0, e.size});
         chk("arburst", {62'd0, arburst}, 64'd1);
         if (arready) begin
            void'(ar_q.pop_front());
            bq.push_back('{int'(e.id), int'(e.len) + 1});
         end
      end else begin
         chk("arvalid_idle", {63'd0, arvalid}, 64'd0);
      end
      if (ret_valid != 0 || ret_last != 0 || ret_q.size() > 0) begin
         if (ret_q.size() == 0) begin
            chk("ret_unexpected", {60'd0, ret_valid, ret_last}, 64'd0);
         end else begin
            r = ret_q.pop_front();
            chk("ret_valid", {62'd0, ret_valid}, {62'd0, r.v});
            chk("ret_last", {62'd0, ret_last}, {62'd0, r.l});
            chk("ret_data", {32'd0, ret_data}, {32'd0, r.d});
         end
      end
   end

   // Reference model: round-robin over eligible ports, one burst per port.
   always @(negedge clk) begin
      int  g;
      int  j;
      ar_t e;
      logic [2:0] ty;
      #1;
      gnt_m = '0;
      g = -1;
      if (!resetn) begin
         chk("rd_rdy_rst", {62'd0, rd_rdy}, 64'd0);
         outst_m = '0;
         rr_m = N - 1;
         ar_q.delete();
         ret_q.delete();
      end else begin
         if (ar_q.size() == 0) begin
            for (int k = 1; k <= N; k++) begin
               j = (rr_m + k) % N;
               if (g < 0 && elig(j)) g = j;
            end
         end
         chk("rd_rdy", {62'd0, rd_rdy},
             (g < 0) ? 64'd0 : (64'd1 << g));
         if (beat_hit && beat_last) outst_m[beat_id] = 0;
         if (g >= 0) begin
            outst_m[g] = 1;
            rr_m = g;
            gnt_m[g] = 1;
            ty = rd_type[3*g +: 3];
            e.id   = IW'(g);
            e.addr = rd_addr[32*g +: 32];
            e.len  = (ty == 3'b100) ? 8'd3 : 8'd0;
            e.size = (ty == 3'b000) ? 3'd0 : (ty == 3'b001) ? 3'd1 : 3'd2;
            ar_q.push_back(e);
         end
      end
   end

   function automatic logic [2:0] pick_type();
      logic [2:0] t;
      case ($urandom_range(0, 5))
         0: t = 3'b000;
         1: t = 3'b001;
         2: t = 3'b010;
         5: t = 3'($urandom);
         default: t = 3'b100;
      endcase
      return t;
   endfunction

   initial begin
      int   b;
      int   stall;
      ret_t r;
      resetn = 0; rd_req = '0; rd_type = '0; rd_addr = '0;
      wb_busy = 0; wb_addr = '0; arready = 0;
      rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
      repeat (3) @(posedge clk);
      #1 resetn = 1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 1500 || cyc == 3000) resetn = 0;
         else if (cyc == 1502 || cyc == 3002) resetn = 1;

         for (int i = 0; i < N; i++) begin
            if (!rd_req[i] || gnt_m[i]) begin
               rd_req[i] = ($urandom_range(0, 99) < 70);
               rd_type[3*i +: 3] = pick_type();
               rd_addr[32*i +: 32] = 32'h1000 +
                  ($urandom_range(0, 7) << 4) + $urandom_range(0, 15);
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            wb_busy = 1'($urandom_range(0, 1));
            wb_addr = 32'h1000 + ($urandom_range(0, 7) << 4);
         end
         stall = ((cyc % 400) < 100) ? 15 : 60;
         arready = resetn && ($urandom_range(0, 99) < stall);

         rvalid = 0; rlast = 0; beat_hit = 0; beat_last = 0;
         if (!resetn) begin
            bq.delete();
            rvalid = 1;
            rid = (cyc % 2 == 0) ? 4'd0 : 4'd5;
            rdata = $urandom;
         end else if (cyc == 1502 || cyc == 3002) begin
            rvalid = 1; rid = '0; rdata = $urandom; rlast = 1;
         end else if (bq.size() > 0 && $urandom_range(0, 99) < 60) begin
            b = $urandom_range(0, bq.size() - 1);
            rvalid = 1;
            rid = IW'(bq[b].id);
            rdata = $urandom;
            rresp = 2'($urandom);
            rlast = (bq[b].left == 1);
            beat_id = bq[b].id;
            beat_hit = outst_m[beat_id];
            beat_last = rlast;
            if (beat_hit) begin
               r.v = '0; r.l = '0;
               r.v[beat_id] = 1'b1;
               r.l[beat_id] = rlast;
               r.d = rdata;
               ret_q.push_back(r);
            end
            bq[b].left = bq[b].left - 1;
            if (bq[b].left == 0) bq.delete(b);
         end else if ($urandom_range(0, 19) == 0) begin
            rvalid = 1;
            rid = IW'($urandom_range(N, 2**IW - 1));
            rdata = $urandom;
            rlast = 1'($urandom);
         end
      end
      @(negedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
